// File: rtl/plic_claim_ctrl_if.sv
// -----------------------------------------------------------------------------
// plic_claim_ctrl_if
// Request/response bus between the claim controller and the PLIC target's
// claim/complete register.
//
// Signals (suffixes are from the controller's point of view):
//   mem_v_o          request valid
//   mem_w_o          1 = write (complete), 0 = read (claim)
//   mem_addr_o       byte address of the claim/complete register
//   mem_data_o       write data (claimed ID, zero-extended)
//   mem_ready_i      request accepted when mem_v_o & mem_ready_i
//   mem_resp_v_i     one response per accepted request
//   mem_resp_data_i  read data
//
// Modports: master = controller, slave = bus / PLIC side.
// -----------------------------------------------------------------------------
interface plic_claim_ctrl_if;
    logic        mem_v_o;
    logic        mem_w_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic        mem_ready_i;
    logic        mem_resp_v_i;
    logic [31:0] mem_resp_data_i;

    modport master (
        output mem_v_o,
        output mem_w_o,
        output mem_addr_o,
        output mem_data_o,
        input  mem_ready_i,
        input  mem_resp_v_i,
        input  mem_resp_data_i
    );

    modport slave (
        input  mem_v_o,
        input  mem_w_o,
        input  mem_addr_o,
        input  mem_data_o,
        output mem_ready_i,
        output mem_resp_v_i,
        output mem_resp_data_i
    );
endinterface

// File: rtl/plic_claim_ctrl.sv
// -----------------------------------------------------------------------------
// plic_claim_ctrl
// Services a PLIC target: on a level interrupt it reads the claim/complete
// register to claim an ID, presents that ID to the core, and once the core is
// done writes the same ID back to complete it. After a complete, a short
// holdoff keeps the still-high irq_i (the PLIC needs a moment to drop it) from
// starting a redundant claim.
//
// Ports:
//   clk_i        sole clock, rising edge
//   reset_i      synchronous, active-high reset
//   irq_i        level interrupt notification from the PLIC target
//   mem          claim/complete bus (plic_claim_ctrl_if.master)
//   intr_v_o     claimed interrupt presented to the core
//   intr_id_o    claimed ID, valid while intr_v_o
//   intr_done_i  core finished its handler (sampled only while intr_v_o)
//   spurious_o   one-cycle pulse: claim returned no usable ID
//   err_o        one-cycle pulse: response timeout
//
// Build option: PLIC_CLAIM_TIMEOUT_EN adds a response timeout of TimeoutCycles
// cycles in both response states. Without it err_o is tied low and the
// response states wait indefinitely.
//
// The address bus is a constant (CcAddr); only mem_v_o qualifies it.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// IDLE       | waiting for irq_i with holdoff expired
// CLAIM_REQ  | read request to the claim register on the bus
// CLAIM_RESP | waiting for the claim read data
// ACTIVE     | ID presented to the core, waiting for intr_done_i
// CMPL_REQ   | write request of the claimed ID (complete)
// CMPL_RESP  | waiting for the complete write response
// -----------------------------------------------------------------------------
module plic_claim_ctrl #(
    parameter int          NumSrc        = 32,
    parameter logic [31:0] CcAddr        = 32'h0020_0004,
    parameter int          HoldoffCycles = 2,
    parameter int          TimeoutCycles = 255,
    localparam int         SRCW          = $clog2(NumSrc)
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                irq_i,
    plic_claim_ctrl_if.master   mem,
    output logic                intr_v_o,
    output logic [SRCW-1:0]     intr_id_o,
    input  logic                intr_done_i,
    output logic                spurious_o,
    output logic                err_o
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        CLAIM_REQ  = 3'd1,
        CLAIM_RESP = 3'd2,
        ACTIVE     = 3'd3,
        CMPL_REQ   = 3'd4,
        CMPL_RESP  = 3'd5
    } state_t;

    // A holdoff of 0 would let a stale irq_i re-claim immediately.
    localparam int HoldoffEff = (HoldoffCycles < 1) ? 1 : HoldoffCycles;
    localparam int HoW        = $clog2(HoldoffEff + 1);
    localparam logic [HoW-1:0] HoldoffLoad = HoW'(HoldoffEff);

    // Bits of the response word that may carry an ID; anything outside this
    // mask makes the claim unusable.
    localparam logic [31:0] IdMask = (32'd1 << SRCW) - 32'd1;

    state_t            state_q;
    state_t            state_d;
    logic [HoW-1:0]    holdoff_q;
    logic [SRCW-1:0]   id_q;
    logic              spurious_q;

    logic              hold_load;
    logic              id_latch;
    logic              spur_d;

    logic [SRCW-1:0]   resp_id;
    logic              resp_bad;

    assign resp_id  = mem.mem_resp_data_i[SRCW-1:0];
    assign resp_bad = (resp_id == '0) || ((mem.mem_resp_data_i & ~IdMask) != 32'd0);

`ifdef PLIC_CLAIM_TIMEOUT_EN
    localparam int TmoEff = (TimeoutCycles < 1) ? 1 : TimeoutCycles;
    localparam int TmW    = $clog2(TmoEff + 1);
    localparam logic [TmW-1:0] TmoLoad = TmW'(TmoEff);

    logic [TmW-1:0]    tmo_cnt_q;
    logic              tmo_expire;
    logic              err_q;
    logic              err_d;
    logic              in_resp;

    assign in_resp    = (state_q == CLAIM_RESP) || (state_q == CMPL_RESP);
    // Counter holds TimeoutCycles on entry; the last waiting cycle sees 1.
    assign tmo_expire = in_resp && (tmo_cnt_q == TmW'(1));

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            tmo_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            err_q <= err_d;
            if (!in_resp) begin
                tmo_cnt_q <= TmoLoad;
            end else if (tmo_cnt_q != '0) begin
                tmo_cnt_q <= tmo_cnt_q - TmW'(1);
            end
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    // State and datapath registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            holdoff_q  <= '0;
            id_q       <= '0;
            spurious_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            spurious_q <= spur_d;
            if (id_latch) begin
                id_q <= resp_id;
            end
            if (hold_load) begin
                holdoff_q <= HoldoffLoad;
            end else if ((state_q == IDLE) && (holdoff_q != '0)) begin
                holdoff_q <= holdoff_q - HoW'(1);
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        hold_load = 1'b0;
        id_latch  = 1'b0;
        spur_d    = 1'b0;
`ifdef PLIC_CLAIM_TIMEOUT_EN
        err_d     = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (irq_i && (holdoff_q == '0)) begin
                    state_d = CLAIM_REQ;
                end
            end
            CLAIM_REQ: begin
                if (mem.mem_ready_i) begin
                    state_d = CLAIM_RESP;
                end
            end
            CLAIM_RESP: begin
                if (mem.mem_resp_v_i) begin
                    if (resp_bad) begin
                        spur_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        id_latch = 1'b1;
                        state_d  = ACTIVE;
                    end
                end
`ifdef PLIC_CLAIM_TIMEOUT_EN
                else if (tmo_expire) begin
                    err_d     = 1'b1;
                    hold_load = 1'b1;
                    state_d   = IDLE;
                end
`endif
            end
            ACTIVE: begin
                if (intr_done_i) begin
                    state_d = CMPL_REQ;
                end
            end
            CMPL_REQ: begin
                if (mem.mem_ready_i) begin
                    state_d = CMPL_RESP;
                end
            end
            CMPL_RESP: begin
                if (mem.mem_resp_v_i) begin
                    hold_load = 1'b1;
                    state_d   = IDLE;
                end
`ifdef PLIC_CLAIM_TIMEOUT_EN
                else if (tmo_expire) begin
                    err_d     = 1'b1;
                    hold_load = 1'b1;
                    state_d   = IDLE;
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the state register only, so request fields
    // cannot move while a request is stalled.
    always_comb begin
        mem.mem_v_o    = 1'b0;
        mem.mem_w_o    = 1'b0;
        mem.mem_addr_o = CcAddr;
        mem.mem_data_o = 32'd0;
        intr_v_o       = 1'b0;
        unique case (state_q)
            CLAIM_REQ: begin
                mem.mem_v_o = 1'b1;
            end
            CMPL_REQ: begin
                mem.mem_v_o    = 1'b1;
                mem.mem_w_o    = 1'b1;
                mem.mem_data_o = 32'(id_q);
            end
            ACTIVE: begin
                intr_v_o = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign intr_id_o  = id_q;
    assign spurious_o = spurious_q;

endmodule
